// File: rtl/phase_sequencer.sv
// rtl/phase_sequencer.sv - CPU phase sequencer: exec sync/edge detect, IDLE/RUN/HALTED run state.
// Optional macro INSTR_COUNT_EN adds a 16-bit completed-instruction counter output.
module phase_sequencer #(
  parameter int PHASE_LAST  = 5,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        exec,
  input  logic        step_mode,
  input  logic        hlt,
  output logic [2:0]  phase,
  output logic        running,
  output logic        halted,
  output logic        instr_done
`ifdef INSTR_COUNT_EN
  ,
  output logic [15:0] instr_count
`endif
);

  localparam logic [2:0] LAST = 3'(PHASE_LAST);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_HALTED = 2'd2
  } state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   exec_prev;
  logic                   exec_pulse;
  logic                   stop_pending;

  // exec is a raw button level; sync first, then detect its rising edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q    <= '0;
      exec_prev <= 1'b0;
    end else begin
      sync_q    <= {sync_q[SYNC_STAGES-2:0], exec};
      exec_prev <= sync_q[SYNC_STAGES-1];
    end
  end

  assign exec_pulse = sync_q[SYNC_STAGES-1] & ~exec_prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      phase        <= 3'd0;
      running      <= 1'b0;
      halted       <= 1'b0;
      instr_done   <= 1'b0;
      stop_pending <= 1'b0;
`ifdef INSTR_COUNT_EN
      instr_count  <= 16'd0;
`endif
    end else begin
      instr_done <= 1'b0;
      case (state)
        S_IDLE: begin
          phase        <= 3'd0;
          running      <= 1'b0;
          halted       <= 1'b0;
          stop_pending <= 1'b0;
          if (exec_pulse) begin
            state   <= S_RUN;
            phase   <= 3'd1;
            running <= 1'b1;
          end
        end
        S_RUN: begin
          if (phase == 3'd0 || phase > LAST) begin
            // Out-of-range phase can only come from an upset; drop back to idle.
            state        <= S_IDLE;
            phase        <= 3'd0;
            running      <= 1'b0;
            stop_pending <= 1'b0;
          end else if (phase == LAST) begin
            instr_done <= 1'b1;
`ifdef INSTR_COUNT_EN
            instr_count <= instr_count + 16'd1;
`endif
            if (hlt) begin
              state        <= S_HALTED;
              phase        <= 3'd0;
              running      <= 1'b0;
              halted       <= 1'b1;
              stop_pending <= 1'b0;
            end else if (stop_pending || step_mode) begin
              state        <= S_IDLE;
              phase        <= 3'd0;
              running      <= 1'b0;
              stop_pending <= 1'b0;
            end else begin
              phase <= 3'd1;
              if (exec_pulse) stop_pending <= 1'b1;
            end
          end else begin
            phase <= phase + 3'd1;
            if (exec_pulse) stop_pending <= 1'b1;
          end
        end
        S_HALTED: begin
          phase        <= 3'd0;
          running      <= 1'b0;
          halted       <= 1'b1;
          stop_pending <= 1'b0;
        end
        default: begin
          state        <= S_IDLE;
          phase        <= 3'd0;
          running      <= 1'b0;
          halted       <= 1'b0;
          stop_pending <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/phase_sequencer.md
Name: phase_sequencer

Overview:
- Generates the 3-bit `phase` value that drives the CPU control decoder.
- Consumes the decoder's `hlt` status and the operator run/stop and single-step inputs.
- Owns the CPU run state: idle, running, or halted.
- Sits between the board-level button inputs and the control decoder / datapath enables.

Parameters:
PHASE_LAST, 5, last phase of an instruction; `phase` cycles 1..PHASE_LAST while running (3-bit field, legal 1..7)
SYNC_STAGES, 2, flip-flop stages in the `exec` input synchronizer (min 2)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-high reset
exec  input  1  asynchronous run/stop button level, active-high
step_mode  input  1  1 = stop after each instruction (single step)
hlt  input  1  HLT-instruction indication from control decoder, valid only when phase != 0
phase  output  3  current phase; 0 = idle/halted, 1..PHASE_LAST = executing
running  output  1  1 while in RUN state
halted  output  1  1 while in HALTED state (sticky until rst)
instr_done  output  1  one-cycle pulse after each completed instruction

Behaviour:
- Reset (async, rst=1): state=IDLE, phase=0, running=0, halted=0, instr_done=0, stop_pending=0, synchronizer flops cleared.
- exec path:
  - SYNC_STAGES-flop synchronizer, then a registered previous-value flop.
  - exec_pulse = sync_out & ~prev (internal, one cycle per rising edge of exec).
  - Level held high yields exactly one pulse; bounces longer than one clock yield multiple pulses (no debounce in this block).
- States:
  - IDLE: phase=0. On exec_pulse → RUN, phase=1 on the same edge.
  - RUN: phase increments by 1 each clock. At phase==PHASE_LAST, the next edge selects, by priority:
    1. hlt=1 → HALTED, phase=0.
    2. stop_pending=1 or step_mode=1 → IDLE, phase=0, stop_pending cleared.
    3. Otherwise → phase=1 (next instruction).
  - An exec_pulse while in RUN sets stop_pending; the current instruction always completes. A second pulse before completion has no further effect.
  - HALTED: phase=0, halted=1. exec_pulse is ignored; exit only via rst.
- hlt is ignored whenever phase==0, or phase != PHASE_LAST.
- instr_done: registered; high for exactly one cycle following every clock edge that leaves phase==PHASE_LAST, including transitions to IDLE and HALTED.
- running = (state==RUN); halted = (state==HALTED). Both are registered and update on the same edge as phase.
- step_mode is sampled only at phase==PHASE_LAST; changing it mid-instruction has no effect until then.
- Phase never takes values above PHASE_LAST. Illegal state encoding recovers to IDLE, phase=0, on the next edge.
- Reset mid-instruction aborts immediately; no instr_done pulse is generated.

Optional Feature:
- Macro INSTR_COUNT_EN.
- Defined: adds output port `instr_count` [15:0].
  - Increments by 1 on every edge that asserts instr_done next cycle; the new value is visible with instr_done.
  - Wraps 0xFFFF → 0x0000.
  - Cleared by rst; holds value while IDLE/HALTED.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
1. Reset, exec rises once (held high 10 cycles) with step_mode=0 → one exec_pulse; phase 1,2,3,4,5,1,2… continuously; running=1; instr_done pulses every 5 cycles.
2. While running, second exec pulse arrives during phase 2 → phase continues 3,4,5 then 0; running=0; one instr_done pulse; stop_pending cleared.
3. step_mode=1, three exec pulses spaced 20 cycles apart → exactly three phase 1..5 sequences, phase=0 between them, three instr_done pulses (instr_count=3 with INSTR_COUNT_EN).
4. hlt=1 during phases 3..5 of the second instruction, with a stop pulse in the same instruction → HALTED wins: phase=0, halted=1, running=0; further exec pulses leave phase=0 until rst.
5. rst asserted asynchronously mid-phase 3 → phase=0, running=0, halted=0 immediately without a clock edge; no instr_done; after release, exec restarts at phase 1.
6. With INSTR_COUNT_EN, preload by running 65536 instructions → instr_count wraps to 0x0000 on the 65536th instr_done.
